// File: rtl/knn_pkg.sv
// Shared widths, payload layouts and sequencer state encoding for the KNN block.
package knn_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned LABEL_W = 8;
  localparam int unsigned DATA_W  = 2 * COORD_W;
  localparam int unsigned POINT_W = 2 * COORD_W + LABEL_W;
  localparam int unsigned NB_W    = 40;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned INS_LAT = 1;

  // Test point as stored in test memory
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } test_pt_t;

  // Training point as stored in data memory
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [LABEL_W-1:0] label;
  } data_pt_t;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_T = 3'd1;
  localparam logic [2:0] ST_CLR    = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_OUT    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

endpackage

// File: rtl/knn_idx_cnt.sv
// Loadable up-counter with a terminal-count flag against a programmable last value.
module knn_idx_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  // Counter register: load has priority over increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc_c = (cnt == last);

endmodule

// File: rtl/knn_seq_ctrl.sv
// Batch sequencer feeding test/training points into calc_insert and returning neighbour lists.
module knn_seq_ctrl #(
  parameter int unsigned DATA_W  = knn_pkg::DATA_W,
  parameter int unsigned POINT_W = knn_pkg::POINT_W,
  parameter int unsigned NB_W    = knn_pkg::NB_W,
  parameter int unsigned ADDR_W  = knn_pkg::ADDR_W,
  parameter int unsigned INS_LAT = knn_pkg::INS_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  n_test,
  input  logic [ADDR_W-1:0]  n_data,
  output logic               busy,
  output logic               done,
  output logic               test_rd,
  output logic [ADDR_W-1:0]  test_addr,
  input  logic [DATA_W-1:0]  test_rdata,
  output logic               data_rd,
  output logic [ADDR_W-1:0]  data_addr,
  input  logic [POINT_W-1:0] data_rdata,
  output logic               ci_rst,
  output logic               ci_en,
  output logic [DATA_W-1:0]  ci_test,
  output logic [POINT_W-1:0] ci_data,
  input  logic [NB_W-1:0]    ci_neighbours,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ADDR_W-1:0]  res_idx,
  output logic [NB_W-1:0]    res_data
);

  import knn_pkg::*;

  localparam int unsigned DR_W = $clog2(INS_LAT + 2);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] n_test_q, n_data_q;
  logic [ADDR_W-1:0] t_idx, d_idx;
  logic              t_tc, d_tc;
  logic              t_ld, t_inc, d_ld, d_inc;
  logic              accept, cap;
  logic [DR_W-1:0]   dr_cnt;

  knn_idx_cnt #(.W(ADDR_W)) u_t_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld     (t_ld),
    .ld_val ('0),
    .inc    (t_inc),
    .last   (n_test_q - ADDR_W'(1)),
    .cnt    (t_idx),
    .tc_c   (t_tc)
  );

  knn_idx_cnt #(.W(ADDR_W)) u_d_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld     (d_ld),
    .ld_val ('0),
    .inc    (d_inc),
    .last   (n_data_q - ADDR_W'(1)),
    .cnt    (d_idx),
    .tc_c   (d_tc)
  );

  assign test_addr = t_idx;
  assign data_addr = d_idx;
  assign ci_data   = data_rdata;

  // Next-state and counter control
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cap       = 1'b0;
    t_ld      = 1'b0;
    t_inc     = 1'b0;
    d_ld      = 1'b0;
    d_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          t_ld      = 1'b1;
          state_nxt = (n_test == '0) ? ST_DONE : ST_LOAD_T;
        end
      end
      ST_LOAD_T: state_nxt = ST_CLR;
      ST_CLR: begin
        d_ld      = 1'b1;
        state_nxt = (n_data_q == '0) ? ST_DRAIN : ST_STREAM;
      end
      ST_STREAM: begin
        if (d_tc) state_nxt = ST_DRAIN;
        else      d_inc     = 1'b1;
      end
      ST_DRAIN: begin
        if (dr_cnt == DR_W'(INS_LAT)) begin
          cap       = 1'b1;
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (res_valid && res_ready) begin
          if (t_tc) begin
            state_nxt = ST_DONE;
          end else begin
            t_inc     = 1'b1;
            state_nxt = ST_LOAD_T;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, registered strobes and captured payloads
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      test_rd   <= 1'b0;
      data_rd   <= 1'b0;
      ci_en     <= 1'b0;
      ci_rst    <= 1'b1;
      res_valid <= 1'b0;
      ci_test   <= '0;
      res_idx   <= '0;
      res_data  <= '0;
      n_test_q  <= '0;
      n_data_q  <= '0;
      dr_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
      test_rd   <= (state_nxt == ST_LOAD_T);
      data_rd   <= (state_nxt == ST_STREAM);
      ci_en     <= data_rd;
      ci_rst    <= (state_nxt == ST_CLR);
      res_valid <= (state_nxt == ST_OUT);
      if (accept) begin
        n_test_q <= n_test;
        n_data_q <= n_data;
      end
      if (state == ST_CLR) ci_test <= test_rdata;
      if (state == ST_DRAIN) dr_cnt <= dr_cnt + DR_W'(1);
      else                   dr_cnt <= '0;
      if (cap) begin
        res_data <= ci_neighbours;
        res_idx  <= t_idx;
      end
    end
  end

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// Self-checking bench for knn_seq_ctrl with memory models and a nearest-neighbour calc_insert stand-in.
module tb_knn_seq_ctrl;
  import knn_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  n_test = '0;
  logic [ADDR_W-1:0]  n_data = '0;
  logic               busy, done, test_rd, data_rd, ci_rst, ci_en, res_valid;
  logic               res_ready = 1'b0;
  logic [ADDR_W-1:0]  test_addr, data_addr, res_idx;
  logic [DATA_W-1:0]  test_rdata = '0;
  logic [POINT_W-1:0] data_rdata = '0;
  logic [DATA_W-1:0]  ci_test;
  logic [POINT_W-1:0] ci_data;
  logic [NB_W-1:0]    ci_neighbours, res_data;

  knn_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .n_test(n_test), .n_data(n_data),
    .busy(busy), .done(done),
    .test_rd(test_rd), .test_addr(test_addr), .test_rdata(test_rdata),
    .data_rd(data_rd), .data_addr(data_addr), .data_rdata(data_rdata),
    .ci_rst(ci_rst), .ci_en(ci_en), .ci_test(ci_test), .ci_data(ci_data),
    .ci_neighbours(ci_neighbours),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0]  tmem [0:1023];
  logic [POINT_W-1:0] dmem [0:1023];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Manhattan distance between a test point and a training point
  function automatic int unsigned mdist(input logic [DATA_W-1:0] tp, input logic [POINT_W-1:0] dp);
    int ax, ay;
    ax = int'(tp[31:16]) - int'(dp[39:24]);
    ay = int'(tp[15:0])  - int'(dp[23:8]);
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    return int'(ax + ay);
  endfunction

  // Reference: nearest training point among dmem[0..nd-1]; earliest wins ties; empty set gives all-ones
  function automatic logic [NB_W-1:0] nn_ref(input logic [DATA_W-1:0] tp, input int nd);
    logic [NB_W-1:0] best = '1;
    int unsigned bd = 32'hFFFF_FFFF;
    for (int i = 0; i < nd; i++) begin
      if (mdist(tp, dmem[i]) < bd) begin
        bd   = mdist(tp, dmem[i]);
        best = dmem[i];
      end
    end
    return best;
  endfunction

  // Memory models: one-cycle read latency
  always @(posedge clk) begin
    if (test_rd) test_rdata <= tmem[test_addr];
    if (data_rd) data_rdata <= dmem[data_addr];
  end

  // calc_insert stand-in: single nearest neighbour, updated one cycle after ci_en
  logic [NB_W-1:0] st_best = '1;
  int unsigned     st_bd = 32'hFFFF_FFFF;
  int              en_cnt = 0;
  int              order_err = 0;
  always @(posedge clk) begin
    if (ci_rst) begin
      st_best <= '1;
      st_bd   <= 32'hFFFF_FFFF;
      en_cnt  <= 0;
    end else if (ci_en) begin
      if (mdist(ci_test, ci_data) < st_bd) begin
        st_bd   <= mdist(ci_test, ci_data);
        st_best <= ci_data;
      end
      if (ci_data !== dmem[en_cnt]) order_err <= order_err + 1;
      en_cnt <= en_cnt + 1;
    end
  end
  assign ci_neighbours = st_best;

  // Event counters sampled mid-cycle
  int done_cnt = 0, trd_cnt = 0, drd_cnt = 0, crst_cnt = 0;
  always @(negedge clk) begin
    if (done)          done_cnt++;
    if (test_rd)       trd_cnt++;
    if (data_rd)       drd_cnt++;
    if (ci_rst && rst) crst_cnt++;
  end

  // Full batch against the reference model, optional result stall and ignored start pulses
  task automatic run_batch(input int nt, input int nd, input int stall, input bit inject);
    int dc0, tr0, dr0, cr0, w;
    bit injected;
    logic [NB_W-1:0] held;
    for (int t = 0; t < nt; t++) tmem[t] = {16'($urandom_range(0, 63)), 16'($urandom_range(0, 63))};
    for (int i = 0; i < nd; i++)
      dmem[i] = {16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)), 8'($urandom)};
    dc0 = done_cnt; tr0 = trd_cnt; dr0 = drd_cnt; cr0 = crst_cnt;
    injected = 1'b0;
    n_test = ADDR_W'(nt);
    n_data = ADDR_W'(nd);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < nt; t++) begin
      w = 0;
      while (!res_valid && w < nd + 40) begin
        if (inject && !injected && data_rd) begin
          start = 1'b1; n_test = ADDR_W'(7); injected = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        w++;
      end
      start = 1'b0;
      check_val("res_valid_wait", res_valid, 1);
      if (res_valid) begin
        check_val("res_idx", res_idx, t);
        check_val("res_data", res_data, nn_ref(tmem[t], nd));
        check_val("ci_test", ci_test, tmem[t]);
        check_val("ci_en_count", en_cnt, nd);
        held = res_data;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check_val("stall_valid", res_valid, 1);
          check_val("stall_data", res_data, held);
          check_val("stall_no_load", test_rd, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_val("valid_drop", res_valid, 0);
      end
    end
    w = 0;
    while (!done && w < 10) begin
      @(negedge clk);
      w++;
    end
    check_val("done_seen", done, 1);
    if (inject) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("idle_busy", busy, 0);
    check_val("done_pulse_len", done, 0);
    repeat (3) @(negedge clk);
    check_val("still_idle", busy, 0);
    check_val("done_count", done_cnt - dc0, 1);
    check_val("test_reads", trd_cnt - tr0, nt);
    check_val("data_reads", drd_cnt - dr0, nt * nd);
    check_val("clear_count", crst_cnt - cr0, nt);
    check_val("ci_order", order_err, 0);
  endtask

  initial begin
    int w, rv, dc0;

    // Reset and idle
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_ci_rst", ci_rst, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_res_data", res_data, 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("idle_ci_rst", ci_rst, 0);
    check_val("idle_test_rd", test_rd, 0);
    check_val("idle_data_rd", data_rd, 0);
    check_val("idle_done", done, 0);

    // Directed single test, cycle-accurate timeline
    tmem[0] = {16'd3, 16'd2};
    dmem[0] = {16'd11, 16'd11, 8'd1};
    dmem[1] = {16'd8, 16'd8, 8'd1};
    dmem[2] = {16'd3, 16'd3, 8'd0};
    dmem[3] = {16'd2, 16'd2, 8'd1};
    n_test = ADDR_W'(1);
    n_data = ADDR_W'(4);
    start  = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_val("t2_busy", busy, c <= 10);
      check_val("t2_test_rd", test_rd, c == 1);
      check_val("t2_ci_rst", ci_rst, c == 2);
      check_val("t2_data_rd", data_rd, c >= 3 && c <= 6);
      if (c >= 3 && c <= 6) check_val("t2_data_addr", data_addr, c - 3);
      check_val("t2_ci_en", ci_en, c >= 4 && c <= 7);
      check_val("t2_res_valid", res_valid, c == 9);
      check_val("t2_done", done, c == 10);
      if (c == 9) begin
        check_val("t2_res_idx", res_idx, 0);
        check_val("t2_res_data", res_data, {16'd3, 16'd3, 8'd0});
        res_ready = 1'b1;
      end else begin
        res_ready = 1'b0;
      end
    end

    // Two tests with a five-cycle stall on the first result
    run_batch(2, 3, 5, 1'b0);
    // Empty test set, then empty training set
    run_batch(0, 5, 0, 1'b0);
    run_batch(1, 0, 0, 1'b0);
    // start during STREAM and DONE is ignored
    run_batch(2, 6, 1, 1'b1);
    // Randomized batches
    for (int k = 0; k < 6; k++)
      run_batch($urandom_range(1, 4), $urandom_range(1, 12), $urandom_range(0, 3), 1'b0);

    // Reset in the middle of streaming
    n_test = ADDR_W'(1);
    n_data = ADDR_W'(20);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!data_rd && w < 10) begin
      @(negedge clk);
      w++;
    end
    check_val("abort_streaming", data_rd, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_val("abort_busy", busy, 0);
    check_val("abort_ci_en", ci_en, 0);
    check_val("abort_data_rd", data_rd, 0);
    check_val("abort_ci_rst", ci_rst, 1);
    check_val("abort_res_valid", res_valid, 0);
    dc0 = done_cnt;
    rv  = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid || busy) rv++;
    end
    check_val("abort_no_done", done_cnt - dc0, 0);
    check_val("abort_quiet", rv, 0);

    // Recovery after abort
    run_batch(3, 7, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
